// File: rtl/rx_bitalign_lane_sequencer.sv
// Trains NUM_LANES bit-align lanes one at a time, with restart, timeout, eye grading and retries.
// Optional macro SEQ_RETRY_STATS_EN enables the RETRY_TOTAL counter (tied to zero otherwise).
module rx_bitalign_lane_sequencer #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned TIMEOUT_W = 16,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned MIN_EYE   = 8,
  localparam int unsigned LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                   SCLK,
  input  logic                   RESETN,
  input  logic                   PLL_LOCK,
  input  logic                   SEQ_START,
  input  logic [NUM_LANES-1:0]   LANE_DONE,
  input  logic [NUM_LANES-1:0]   LANE_ERR,
  input  logic [8*NUM_LANES-1:0] LANE_LEFT_WIN,
  input  logic [8*NUM_LANES-1:0] LANE_RGHT_WIN,
  output logic [NUM_LANES-1:0]   LANE_RSTRT,
  output logic [NUM_LANES-1:0]   LANE_HOLD,
  output logic [LW-1:0]          CUR_LANE,
  output logic                   SEQ_BUSY,
  output logic                   SEQ_DONE,
  output logic [NUM_LANES-1:0]   LANE_PASS,
  output logic [NUM_LANES-1:0]   LANE_FAIL,
  output logic [7:0]             RETRY_TOTAL
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_KICK      = 3'd2;
  localparam logic [2:0] S_WAIT_CLR  = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_CHECK     = 3'd5;
  localparam logic [2:0] S_NEXT      = 3'd6;
  localparam logic [2:0] S_FINISH    = 3'd7;

  logic [2:0]           state_q, state_d;
  logic [LW-1:0]        cur_q, cur_d;
  logic [3:0]           retry_q, retry_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic                 bad_q, bad_d;
  logic [NUM_LANES-1:0] rstrt_q, rstrt_d, hold_q, hold_d, pass_q, pass_d, fail_q, fail_d;
  logic                 busy_q, busy_d, done_q, done_d;

  logic [7:0] lane_left, lane_rght;
  logic [8:0] eye_sum;
  logic       lane_done, lane_err, timer_max, att_pass;
  logic       start_go, lock_lost, retry_go;

  assign lane_done = LANE_DONE[cur_q];
  assign lane_err  = LANE_ERR[cur_q];
  assign lane_left = LANE_LEFT_WIN[8*int'(cur_q) +: 8];
  assign lane_rght = LANE_RGHT_WIN[8*int'(cur_q) +: 8];
  assign eye_sum   = {1'b0, lane_left} + {1'b0, lane_rght};
  assign timer_max = (timer_q == '1);
  assign att_pass  = !bad_q && (eye_sum >= 9'(MIN_EYE));
  assign start_go  = (state_q == S_IDLE) && SEQ_START;
  assign lock_lost = !PLL_LOCK && (state_q != S_IDLE) && (state_q != S_WAIT_LOCK);
  assign retry_go  = (state_q == S_CHECK) && !att_pass && (retry_q < 4'(MAX_RETRY)) && !lock_lost;

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    retry_d = retry_q;
    timer_d = timer_q;
    bad_d   = bad_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    done_d  = done_q;

    case (state_q)
      S_IDLE: begin
        if (start_go) begin
          state_d = S_WAIT_LOCK;
          done_d  = 1'b0;
          pass_d  = '0;
          fail_d  = '0;
          cur_d   = '0;
          retry_d = '0;
        end
      end
      S_WAIT_LOCK: if (PLL_LOCK) state_d = S_KICK;
      S_KICK: begin
        timer_d = '0;
        state_d = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        if (!lane_done && !lane_err) begin
          state_d = S_WAIT_DONE;
          timer_d = '0;
        end else if (timer_max) begin
          bad_d   = 1'b1;
          state_d = S_CHECK;
        end else begin
          timer_d = timer_q + TIMEOUT_W'(1);
        end
      end
      S_WAIT_DONE: begin
        // DONE and ERR together grade as an error
        if (lane_done || lane_err) begin
          bad_d   = lane_err;
          state_d = S_CHECK;
        end else if (timer_max) begin
          bad_d   = 1'b1;
          state_d = S_CHECK;
        end else begin
          timer_d = timer_q + TIMEOUT_W'(1);
        end
      end
      S_CHECK: begin
        if (att_pass) begin
          pass_d[cur_q] = 1'b1;
          state_d       = S_NEXT;
        end else if (retry_go) begin
          retry_d = retry_q + 4'd1;
          state_d = S_KICK;
        end else begin
          fail_d[cur_q] = 1'b1;
          state_d       = S_NEXT;
        end
      end
      S_NEXT: begin
        retry_d = '0;
        if (cur_q == LW'(NUM_LANES - 1)) begin
          state_d = S_FINISH;
        end else begin
          cur_d   = cur_q + LW'(1);
          state_d = S_KICK;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Losing lock restarts training from lane 0 with results discarded
    if (lock_lost) begin
      state_d = S_WAIT_LOCK;
      cur_d   = '0;
      retry_d = '0;
      timer_d = '0;
      bad_d   = 1'b0;
      pass_d  = '0;
      fail_d  = '0;
    end

    if (state_d == S_FINISH) done_d = 1'b1;
    busy_d  = (state_d != S_IDLE) && (state_d != S_FINISH);
    rstrt_d = (state_d == S_KICK) ? (NUM_LANES'(1) << cur_d) : '0;
    hold_d  = busy_d ? ~(NUM_LANES'(1) << cur_d) : '0;
  end

  always_ff @(posedge SCLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      retry_q <= '0;
      timer_q <= '0;
      bad_q   <= 1'b0;
      rstrt_q <= '0;
      hold_q  <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      retry_q <= retry_d;
      timer_q <= timer_d;
      bad_q   <= bad_d;
      rstrt_q <= rstrt_d;
      hold_q  <= hold_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign LANE_RSTRT = rstrt_q;
  assign LANE_HOLD  = hold_q;
  assign CUR_LANE   = cur_q;
  assign SEQ_BUSY   = busy_q;
  assign SEQ_DONE   = done_q;
  assign LANE_PASS  = pass_q;
  assign LANE_FAIL  = fail_q;

`ifdef SEQ_RETRY_STATS_EN
  logic [7:0] retry_total_q;

  // Saturating count of retries in the current sequence
  always_ff @(posedge SCLK or negedge RESETN) begin
    if (!RESETN) begin
      retry_total_q <= '0;
    end else if (start_go || lock_lost) begin
      retry_total_q <= '0;
    end else if (retry_go && (retry_total_q != 8'hFF)) begin
      retry_total_q <= retry_total_q + 8'd1;
    end
  end

  assign RETRY_TOTAL = retry_total_q;
`else
  assign RETRY_TOTAL = 8'd0;
`endif

endmodule

// File: tb/tb_rx_bitalign_lane_sequencer.sv
// Bench for rx_bitalign_lane_sequencer: directed scenario table, hand sequences, randomized lanes.
module tb_rx_bitalign_lane_sequencer;

  localparam int NL = 4;
  localparam int MR = 3;
  localparam int ME = 8;
`ifdef SEQ_RETRY_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int K_DONE = 0, K_ERR = 1, K_BOTH = 2, K_SILENT = 3, K_STUCK = 4;
  localparam int M_GOOD = 0, M_ERR = 1, M_WIN = 2, M_STUCK = 3, M_BOTH = 4, M_ERR1 = 5;

  logic        SCLK = 1'b0;
  logic        RESETN, PLL_LOCK, SEQ_START;
  logic [3:0]  LANE_DONE, LANE_ERR;
  logic [31:0] LANE_LEFT_WIN, LANE_RGHT_WIN;
  logic [3:0]  LANE_RSTRT, LANE_HOLD, LANE_PASS, LANE_FAIL;
  logic [1:0]  CUR_LANE;
  logic        SEQ_BUSY, SEQ_DONE;
  logic [7:0]  RETRY_TOTAL;

  rx_bitalign_lane_sequencer #(.NUM_LANES(NL), .TIMEOUT_W(6), .MAX_RETRY(MR), .MIN_EYE(ME)) dut (
    .SCLK(SCLK), .RESETN(RESETN), .PLL_LOCK(PLL_LOCK), .SEQ_START(SEQ_START),
    .LANE_DONE(LANE_DONE), .LANE_ERR(LANE_ERR),
    .LANE_LEFT_WIN(LANE_LEFT_WIN), .LANE_RGHT_WIN(LANE_RGHT_WIN),
    .LANE_RSTRT(LANE_RSTRT), .LANE_HOLD(LANE_HOLD), .CUR_LANE(CUR_LANE),
    .SEQ_BUSY(SEQ_BUSY), .SEQ_DONE(SEQ_DONE), .LANE_PASS(LANE_PASS),
    .LANE_FAIL(LANE_FAIL), .RETRY_TOTAL(RETRY_TOTAL)
  );

  always #5 SCLK = ~SCLK;

  int total = 0;
  int bad = 0;
  int gen = 0;
  int mon_viol = 0;
  int kind [4][4];
  int al [4][4];
  int ar [4][4];
  int dly [4][4];
  int order_q [$];

  typedef struct {
    int         mode [4];
    logic [3:0] pass;
    logic [3:0] fail;
    int         rt;
    int         kk [4];
  } row_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    total++;
    if (act !== ex) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, ex);
    end
  endtask

  // Lane responder plus per-cycle protocol monitor
  initial begin : lane_model
    int seen_gen, a;
    int cnt [4];
    int kicks [4];
    int att [4];
    logic [3:0] prev_rstrt, exp_hold;
    seen_gen = 0; prev_rstrt = '0;
    LANE_DONE = '0; LANE_ERR = '0; LANE_LEFT_WIN = '0; LANE_RGHT_WIN = '0;
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; kicks[i] = 0; att[i] = 0; end
    forever begin
      @(negedge SCLK);
      if (gen != seen_gen) begin
        seen_gen = gen;
        LANE_DONE = '0; LANE_ERR = '0;
        for (int i = 0; i < 4; i++) begin cnt[i] = 0; kicks[i] = 0; end
        order_q.delete();
      end
      if (RESETN === 1'b1) begin
        if (!$onehot0(LANE_RSTRT)) mon_viol++;
        if (LANE_RSTRT != 4'b0 && prev_rstrt != 4'b0) mon_viol++;
        exp_hold = SEQ_BUSY ? ~(4'b0001 << CUR_LANE) : 4'b0000;
        if (LANE_HOLD !== exp_hold) mon_viol++;
        if ((LANE_PASS & LANE_FAIL) != 4'b0) mon_viol++;
        for (int i = 0; i < 4; i++) if (LANE_RSTRT[i] === 1'b1) order_q.push_back(i);
      end
      prev_rstrt = LANE_RSTRT;
      for (int i = 0; i < 4; i++) begin
        if (LANE_RSTRT[i] === 1'b1) begin
          a = (kicks[i] > 3) ? 3 : kicks[i];
          kicks[i]++;
          att[i] = a;
          LANE_LEFT_WIN[8*i +: 8] = 8'(al[i][a]);
          LANE_RGHT_WIN[8*i +: 8] = 8'(ar[i][a]);
          LANE_DONE[i] = (kind[i][a] == K_STUCK);
          LANE_ERR[i]  = 1'b0;
          cnt[i] = dly[i][a];
        end else if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            case (kind[i][att[i]])
              K_DONE:  LANE_DONE[i] = 1'b1;
              K_ERR:   LANE_ERR[i]  = 1'b1;
              K_BOTH:  begin LANE_DONE[i] = 1'b1; LANE_ERR[i] = 1'b1; end
              default: ;
            endcase
          end
        end
      end
    end
  end

  task automatic set_mode(input int i, input int m);
    for (int a = 0; a < 4; a++) begin
      dly[i][a] = 20; al[i][a] = 5; ar[i][a] = 6; kind[i][a] = K_DONE;
      case (m)
        M_ERR:   kind[i][a] = K_ERR;
        M_WIN:   begin al[i][a] = (a == 0) ? 3 : 4; ar[i][a] = 4; end
        M_STUCK: kind[i][a] = K_STUCK;
        M_BOTH:  kind[i][a] = K_BOTH;
        M_ERR1:  kind[i][a] = (a == 0) ? K_ERR : K_DONE;
        default: ;
      endcase
    end
  endtask

  task automatic new_scenario();
    gen++;
    repeat (2) @(negedge SCLK);
  endtask

  task automatic start_seq(input string nm);
    @(negedge SCLK); SEQ_START = 1'b1;
    @(negedge SCLK); SEQ_START = 1'b0;
    chk({nm, "_start_busy"}, {30'b0, SEQ_BUSY, SEQ_DONE}, 32'b10);
    @(negedge SCLK);
    chk({nm, "_first_kick"}, LANE_RSTRT, 4'b0001);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (SEQ_DONE !== 1'b1 && n < 6000) begin @(negedge SCLK); n++; end
    chk({nm, "_finish"}, (n < 6000), 1);
  endtask

  task automatic check_result(input string nm, input logic [3:0] ep, input logic [3:0] ef,
                              input int ert, input int ek [4]);
    int exp_q [$];
    bit ok;
    for (int i = 0; i < 4; i++) for (int k = 0; k < ek[i]; k++) exp_q.push_back(i);
    chk({nm, "_pass"}, LANE_PASS, ep);
    chk({nm, "_fail"}, LANE_FAIL, ef);
    chk({nm, "_retry_total"}, RETRY_TOTAL, STATS ? ert : 0);
    chk({nm, "_kicks"}, order_q.size(), exp_q.size());
    ok = (order_q.size() == exp_q.size());
    if (ok) for (int i = 0; i < exp_q.size(); i++) if (order_q[i] != exp_q[i]) ok = 1'b0;
    chk({nm, "_order"}, ok, 1);
    chk({nm, "_busy_low"}, SEQ_BUSY, 0);
    @(negedge SCLK);
  endtask

  initial begin : main
    row_t rows [6];
    int   ek [4];
    int   n, rt, k, lr;
    logic [3:0] ep, ef;
    bit   passed;

    rows[0] = '{'{M_GOOD, M_GOOD, M_GOOD, M_GOOD},  4'hF, 4'h0, 0, '{1, 1, 1, 1}};
    rows[1] = '{'{M_GOOD, M_GOOD, M_ERR,  M_GOOD},  4'hB, 4'h4, 3, '{1, 1, 4, 1}};
    rows[2] = '{'{M_GOOD, M_WIN,  M_GOOD, M_GOOD},  4'hF, 4'h0, 1, '{1, 2, 1, 1}};
    rows[3] = '{'{M_STUCK, M_GOOD, M_GOOD, M_GOOD}, 4'hE, 4'h1, 3, '{4, 1, 1, 1}};
    rows[4] = '{'{M_GOOD, M_GOOD, M_GOOD, M_BOTH},  4'h7, 4'h8, 3, '{1, 1, 1, 4}};
    rows[5] = '{'{M_ERR1, M_GOOD, M_GOOD, M_WIN},   4'hF, 4'h0, 2, '{2, 1, 1, 2}};

    RESETN = 1'b0; PLL_LOCK = 1'b1; SEQ_START = 1'b0;
    for (int i = 0; i < 4; i++) set_mode(i, M_GOOD);
    repeat (3) @(negedge SCLK);
    chk("reset_outs", {4'b0, LANE_RSTRT, LANE_HOLD, LANE_PASS, LANE_FAIL, CUR_LANE,
                       SEQ_BUSY, SEQ_DONE, RETRY_TOTAL}, 0);
    RESETN = 1'b1;
    @(negedge SCLK);
    chk("idle_after_reset", {4'b0, LANE_RSTRT, LANE_HOLD, LANE_PASS, LANE_FAIL, CUR_LANE,
                             SEQ_BUSY, SEQ_DONE, RETRY_TOTAL}, 0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) set_mode(i, rows[r].mode[i]);
      new_scenario();
      start_seq($sformatf("row%0d", r));
      wait_done($sformatf("row%0d", r));
      chk($sformatf("row%0d_cur_last", r), CUR_LANE, 2'd3);
      check_result($sformatf("row%0d", r), rows[r].pass, rows[r].fail, rows[r].rt, rows[r].kk);
    end

    // SEQ_START while busy must not disturb the run
    for (int i = 0; i < 4; i++) set_mode(i, M_GOOD);
    new_scenario();
    start_seq("busy");
    repeat (30) @(negedge SCLK);
    SEQ_START = 1'b1; @(negedge SCLK); SEQ_START = 1'b0;
    wait_done("busy");
    ek = '{1, 1, 1, 1};
    check_result("busy", 4'hF, 4'h0, 0, ek);

    // PLL lock lost during lane 2
    new_scenario();
    start_seq("lock");
    n = 0;
    while (order_q.size() < 3 && n < 2000) begin @(negedge SCLK); n++; end
    chk("lock_reach_lane2", (n < 2000), 1);
    repeat (5) @(negedge SCLK);
    chk("lock_pass_before", LANE_PASS, 4'b0011);
    PLL_LOCK = 1'b0;
    @(negedge SCLK);
    chk("lock_drop_state", {21'b0, LANE_PASS, LANE_RSTRT, CUR_LANE, SEQ_BUSY}, 32'b1);
    repeat (9) @(negedge SCLK);
    chk("lock_no_kick", order_q.size(), 3);
    PLL_LOCK = 1'b1;
    wait_done("lock");
    chk("lock_pass", LANE_PASS, 4'hF);
    chk("lock_fail", LANE_FAIL, 4'h0);
    chk("lock_kicks", order_q.size(), 7);
    chk("lock_rekick_lane0", (order_q.size() > 3) ? order_q[3] : 9, 0);
    chk("lock_retry_total", RETRY_TOTAL, 0);
    @(negedge SCLK);

    // Randomized lane behaviour graded by an attempt-level model
    for (int s = 0; s < 8; s++) begin
      ep = '0; ef = '0; rt = 0;
      for (int i = 0; i < 4; i++) begin
        for (int a = 0; a < 4; a++) begin
          lr = int'($urandom_range(0, 15));
          kind[i][a] = (lr < 9) ? K_DONE : (lr < 12) ? K_ERR : (lr < 14) ? K_BOTH :
                       (lr < 15) ? K_SILENT : K_STUCK;
          al[i][a]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 7));
          ar[i][a]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 7));
          dly[i][a] = int'($urandom_range(2, 30));
        end
        k = 0; passed = 1'b0;
        while (k <= MR && !passed) begin
          if (kind[i][k] == K_DONE && (al[i][k] + ar[i][k]) >= ME) passed = 1'b1;
          k++;
        end
        ek[i] = k;
        rt += k - 1;
        ep[i] = passed;
        ef[i] = !passed;
      end
      new_scenario();
      start_seq($sformatf("rnd%0d", s));
      wait_done($sformatf("rnd%0d", s));
      check_result($sformatf("rnd%0d", s), ep, ef, rt, ek);
    end

    chk("monitor_violations", mon_viol, 0);

    // Asynchronous reset during lane 1
    for (int i = 0; i < 4; i++) set_mode(i, M_GOOD);
    new_scenario();
    start_seq("rst");
    n = 0;
    while (order_q.size() < 2 && n < 2000) begin @(negedge SCLK); n++; end
    chk("rst_reach_lane1", (n < 2000), 1);
    repeat (3) @(negedge SCLK);
    chk("rst_busy_before", {LANE_PASS, SEQ_BUSY}, 5'b00011);
    #2 RESETN = 1'b0;
    #1;
    chk("rst_outs_zero", {4'b0, LANE_RSTRT, LANE_HOLD, LANE_PASS, LANE_FAIL, CUR_LANE,
                          SEQ_BUSY, SEQ_DONE, RETRY_TOTAL}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
